// File: rtl/cmos_frame_capture_pkg.sv
// Shared types and constants for the OV7670 frame capture front end.
// Imported by the capture top and its byte packer.
package cmos_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    SKIP      = 2'd1,
    CAPTURE   = 2'd2
  } cap_state_t;

  localparam int unsigned DEF_H_PIXELS = 640;
  localparam int unsigned DEF_V_LINES  = 480;

  localparam int SKIP_W = 8;
  localparam int PIX_W  = 11;
  localparam int LINE_W = 10;

endpackage

// File: rtl/cmos_frame_capture_if.sv
// Camera pins in, FIFO write port and frame status out.
// The slave modport is the capture block; the master is the camera/FIFO side.
interface cmos_frame_capture_if;

  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        cmos_frame_we;
  logic [15:0] cmos_frame_data;
  logic        cmos_frame_valid;
  logic        cmos_frame_done;
  logic        cmos_frame_err;

  modport master (
    output cmos_vsync, cmos_href, cmos_data,
    input  cmos_frame_we, cmos_frame_data, cmos_frame_valid,
    input  cmos_frame_done, cmos_frame_err
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data,
    output cmos_frame_we, cmos_frame_data, cmos_frame_valid,
    output cmos_frame_done, cmos_frame_err
  );

endinterface

// File: rtl/cmos_frame_capture_byte_packer.sv
// Pairs consecutive camera bytes into one 16-bit RGB565 word.
// odd reports a first byte still waiting for its partner.
module cmos_byte_packer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        we,
  output logic [15:0] pix,
  output logic        odd
);

  logic       toggle;
  logic [7:0] first;

  // Losing href restarts the pairing so a stray byte never leaks into the next line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= 1'b0;
      first  <= 8'd0;
      we     <= 1'b0;
      pix    <= 16'd0;
    end else begin
      we <= 1'b0;
      if (!href) begin
        toggle <= 1'b0;
      end else if (en) begin
        toggle <= ~toggle;
        if (!toggle) begin
          first <= data;
        end else begin
          we  <= 1'b1;
          pix <= MSB_FIRST ? {first, data} : {data, first};
        end
      end
    end
  end

  assign odd = toggle;

endmodule

// File: rtl/cmos_frame_capture.sv
// OV7670 capture front end: gates on SDRAM init, skips start-up frames,
// packs pixels for the frame buffer FIFO and checks frame geometry.
module cmos_frame_capture
  import cmos_capture_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned H_PIXELS   = DEF_H_PIXELS,
  parameter int unsigned V_LINES    = DEF_V_LINES,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sdram_init_done,
  cmos_frame_capture_if.slave cam
);

  localparam logic [SKIP_W-1:0] SKIP_TARGET = SKIP_W'(FRAME_SKIP);
  localparam logic [PIX_W:0]    H_TARGET    = (PIX_W + 1)'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_TARGET    = LINE_W'(V_LINES);

  logic              init_s1, init_s2;
  logic              vs_r1, vs_r2, hs_r1, line_act_d;
  logic [7:0]        d_r1;
  cap_state_t        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              err_flag;
  logic              fs, line_act, line_end, capturing, pack_en;
  logic              pk_we, pk_odd;
  logic [15:0]       pk_pix;
  logic [PIX_W:0]    pix_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_s1    <= 1'b0;
      init_s2    <= 1'b0;
      vs_r1      <= 1'b0;
      vs_r2      <= 1'b0;
      hs_r1      <= 1'b0;
      d_r1       <= 8'd0;
      line_act_d <= 1'b0;
    end else begin
      init_s1    <= sdram_init_done;
      init_s2    <= init_s1;
      vs_r1      <= cam.cmos_vsync;
      vs_r2      <= vs_r1;
      hs_r1      <= cam.cmos_href;
      d_r1       <= cam.cmos_data;
      line_act_d <= line_act;
    end
  end

  // Gating on init_s2 as well as the state lets an init drop kill pixels already in flight
  assign fs        = vs_r1 & ~vs_r2;
  assign line_act  = hs_r1 & ~vs_r1;
  assign line_end  = line_act_d & ~line_act;
  assign capturing = (state == CAPTURE) & init_s2;
  assign pack_en   = capturing & line_act;
  assign pix_seen  = {1'b0, pix_cnt} + {{PIX_W{1'b0}}, pk_we};

  cmos_byte_packer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk  (clk),
    .rst  (rst),
    .en   (pack_en),
    .href (hs_r1),
    .data (d_r1),
    .we   (pk_we),
    .pix  (pk_pix),
    .odd  (pk_odd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= WAIT_INIT;
      skip_cnt             <= '0;
      cam.cmos_frame_valid <= 1'b0;
    end else begin
      case (state)
        WAIT_INIT: begin
          if (init_s2) begin
            state    <= SKIP;
            skip_cnt <= '0;
          end
        end
        SKIP: begin
          if (!init_s2) begin
            state <= WAIT_INIT;
          end else if (fs) begin
            if (skip_cnt == SKIP_TARGET) begin
              state                <= CAPTURE;
              cam.cmos_frame_valid <= 1'b1;
            end else if (skip_cnt != '1) begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (!init_s2) begin
            state                <= WAIT_INIT;
            cam.cmos_frame_valid <= 1'b0;
          end
        end
        default: begin
          state                <= WAIT_INIT;
          cam.cmos_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  // The last pixel of a line is still in the packer when href falls, hence pix_seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt             <= '0;
      line_cnt            <= '0;
      err_flag            <= 1'b0;
      cam.cmos_frame_we   <= 1'b0;
      cam.cmos_frame_data <= 16'd0;
      cam.cmos_frame_done <= 1'b0;
      cam.cmos_frame_err  <= 1'b0;
    end else begin
      cam.cmos_frame_we   <= pk_we & capturing;
      cam.cmos_frame_done <= fs & capturing;
      cam.cmos_frame_err  <= fs & capturing & (err_flag | (line_cnt != V_TARGET));
      if (pk_we & capturing) begin
        cam.cmos_frame_data <= pk_pix;
      end
      if (!capturing || fs) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        err_flag <= 1'b0;
      end else if (line_end) begin
        if ((pix_seen != H_TARGET) || pk_odd) begin
          err_flag <= 1'b1;
        end
        if (line_cnt != '1) begin
          line_cnt <= line_cnt + 1'b1;
        end
        pix_cnt <= '0;
      end else if (pk_we && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Directed bench for cmos_frame_capture: init gating, frame skip, packing order,
// latency, geometry checking, init drop and asynchronous reset.
module tb_cmos_frame_capture;
  import cmos_capture_pkg::*;

  logic clk;
  logic rst;
  logic sdram_init_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int we_count     = 0;
  int done_count   = 0;
  int err_count    = 0;
  int last_done_cyc = -1;
  int last_err_cyc  = -2;
  logic [15:0] we_data[$];
  logic [15:0] we2_data[$];
  int          we_cyc[$];

  cmos_frame_capture_if cam();
  cmos_frame_capture_if cam2();

  assign cam2.cmos_vsync = cam.cmos_vsync;
  assign cam2.cmos_href  = cam.cmos_href;
  assign cam2.cmos_data  = cam.cmos_data;

  cmos_frame_capture #(
    .FRAME_SKIP (2),
    .H_PIXELS   (4),
    .V_LINES    (2),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .cam             (cam)
  );

  cmos_frame_capture #(
    .FRAME_SKIP (2),
    .H_PIXELS   (4),
    .V_LINES    (2),
    .MSB_FIRST  (1'b0)
  ) dut_lsb (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .cam             (cam2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor samples 1 ns after each rising edge; cyc is the edge number
  always @(posedge clk) begin
    cyc++;
    #1;
    if (cam.cmos_frame_we === 1'b1) begin
      we_count++;
      we_data.push_back(cam.cmos_frame_data);
      we_cyc.push_back(cyc);
    end
    if (cam2.cmos_frame_we === 1'b1) we2_data.push_back(cam2.cmos_frame_data);
    if (cam.cmos_frame_done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (cam.cmos_frame_err === 1'b1) begin
      err_count++;
      last_err_cyc = cyc;
    end
  end

  task automatic applyStimulus(input logic vs, input logic hs, input logic [7:0] d);
    @(negedge clk);
    cam.cmos_vsync = vs;
    cam.cmos_href  = hs;
    cam.cmos_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frameStart();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  task automatic sendLine(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, base + 8'(i));
    idle(4);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int w0, d0, r0, e1, e2;
    rst             = 1'b1;
    sdram_init_done = 1'b0;
    cam.cmos_vsync  = 1'b0;
    cam.cmos_href   = 1'b0;
    cam.cmos_data   = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset_valid", cam.cmos_frame_valid, 0);
    checkOutput("reset_we",    cam.cmos_frame_we,    0);
    checkOutput("reset_data",  cam.cmos_frame_data,  0);
    checkOutput("reset_done",  {cam.cmos_frame_done, cam.cmos_frame_err}, 0);
    checkOutput("reset_state", dut.state, 32'(WAIT_INIT));
    rst = 1'b0;

    // Three frames with SDRAM init still low
    repeat (3) begin
      frameStart();
      sendLine(8, 8'h01);
      sendLine(8, 8'h11);
    end
    checkOutput("gate_valid", cam.cmos_frame_valid, 0);
    checkOutput("gate_we_count", we_count, 0);

    // Init up: two frames skipped, the third frame start enters capture
    sdram_init_done = 1'b1;
    idle(4);
    frameStart();
    sendLine(8, 8'h01);
    frameStart();
    checkOutput("skip_valid_fs2", cam.cmos_frame_valid, 0);
    sendLine(8, 8'h01);
    frameStart();
    checkOutput("skip_valid_fs3", cam.cmos_frame_valid, 1);
    checkOutput("skip_we_count", we_count, 0);
    checkOutput("skip_no_done", done_count, 0);

    // Packing order and latency
    w0 = we_count;
    applyStimulus(1'b0, 1'b1, 8'hAB);
    applyStimulus(1'b0, 1'b1, 8'hCD);
    e1 = cyc + 1;
    applyStimulus(1'b0, 1'b1, 8'h12);
    applyStimulus(1'b0, 1'b1, 8'h34);
    e2 = cyc + 1;
    idle(4);
    checkOutput("pack_we_count", we_count - w0, 2);
    checkOutput("pack_msb_0", we_data[w0], 32'h0000ABCD);
    checkOutput("pack_msb_1", we_data[w0 + 1], 32'h00001234);
    checkOutput("pack_lsb_0", we2_data[w0], 32'h0000CDAB);
    checkOutput("pack_lsb_1", we2_data[w0 + 1], 32'h00003412);
    checkOutput("pack_lat_0", we_cyc[w0], e1 + 2);
    checkOutput("pack_lat_1", we_cyc[w0 + 1], e2 + 2);
    d0 = done_count;
    r0 = err_count;
    frameStart();
    checkOutput("short_frame_done", done_count - d0, 1);
    checkOutput("short_frame_err", err_count - r0, 1);

    // Correct 4x2 frame
    w0 = we_count; d0 = done_count; r0 = err_count;
    sendLine(8, 8'h10);
    sendLine(8, 8'h20);
    frameStart();
    checkOutput("good_we_count", we_count - w0, 8);
    checkOutput("good_last_pix", we_data[we_data.size() - 1], 32'h00002627);
    checkOutput("good_done", done_count - d0, 1);
    checkOutput("good_err", err_count - r0, 0);

    // Second line one byte short
    w0 = we_count; d0 = done_count; r0 = err_count;
    sendLine(8, 8'h30);
    sendLine(7, 8'h40);
    frameStart();
    checkOutput("bad_we_count", we_count - w0, 7);
    checkOutput("bad_last_pix", we_data[we_data.size() - 1], 32'h00004445);
    checkOutput("bad_done", done_count - d0, 1);
    checkOutput("bad_err", err_count - r0, 1);
    checkOutput("bad_err_with_done", last_err_cyc, last_done_cyc);

    d0 = done_count; r0 = err_count;
    sendLine(8, 8'h50);
    sendLine(8, 8'h60);
    frameStart();
    checkOutput("recover_done", done_count - d0, 1);
    checkOutput("recover_err", err_count - r0, 0);

    // Init drop mid-line: the pair completing at the drop is aborted
    w0 = we_count; d0 = done_count;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i));
    sdram_init_done = 1'b0;
    for (int i = 4; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i));
    checkOutput("drop_valid", cam.cmos_frame_valid, 0);
    applyStimulus(1'b0, 1'b1, 8'h77);
    idle(4);
    frameStart();
    sendLine(8, 8'h01);
    checkOutput("drop_we_count", we_count - w0, 1);
    checkOutput("drop_no_done", done_count - d0, 0);

    sdram_init_done = 1'b1;
    w0 = we_count;
    idle(4);
    frameStart();
    sendLine(8, 8'h01);
    frameStart();
    checkOutput("reskip_valid_fs2", cam.cmos_frame_valid, 0);
    sendLine(8, 8'h01);
    frameStart();
    checkOutput("reskip_valid_fs3", cam.cmos_frame_valid, 1);
    checkOutput("reskip_we_count", we_count - w0, 0);

    // Asynchronous reset between the two bytes of a pair
    w0 = we_count;
    applyStimulus(1'b0, 1'b1, 8'h80);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", cam.cmos_frame_valid, 0);
    checkOutput("arst_we", cam.cmos_frame_we, 0);
    checkOutput("arst_state", dut.state, 32'(WAIT_INIT));
    applyStimulus(1'b0, 1'b1, 8'h81);
    applyStimulus(1'b0, 1'b1, 8'h82);
    rst = 1'b0;
    idle(6);
    checkOutput("arst_we_count", we_count - w0, 0);
    checkOutput("arst_valid_after", cam.cmos_frame_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmos_frame_capture.md
Name: cmos_frame_capture

Overview:
- Camera-side front end that feeds the SDRAM frame buffer's write FIFO.
- Runs on the OV7670 pixel clock and samples VSYNC/HREF/D[7:0].
- Packs byte pairs into 16-bit RGB565 words and drives the FIFO write strobe/data plus the frame-valid flag consumed by bank switching.
- Holds off capture until SDRAM init completes and a configurable number of start-up frames has been discarded.

Parameters:
FRAME_SKIP, 10, number of complete frames discarded after init before capture starts (0..255)
H_PIXELS, 640, expected 16-bit pixels per line
V_LINES, 480, expected lines per frame
MSB_FIRST, 1, 1: first byte of a pair is bits [15:8]; 0: first byte is bits [7:0]

Ports:
clk  in  1  camera pixel clock (PCLK); all logic on its rising edge
rst  in  1  asynchronous, active-high reset
sdram_init_done  in  1  from the SDRAM controller (foreign domain); 2-flop synchronised internally
cmos_vsync  in  1  camera VSYNC, active high
cmos_href  in  1  camera HREF, active high
cmos_data  in  8  camera data byte
cmos_frame_we  out  1  FIFO write enable, one-cycle pulse per pixel
cmos_frame_data  out  16  packed RGB565 pixel, valid when cmos_frame_we=1
cmos_frame_valid  out  1  high while in CAPTURE (drives frame_valid)
cmos_frame_done  out  1  one-cycle pulse at the end of each captured frame
cmos_frame_err  out  1  one-cycle pulse together with frame_done when the frame geometry was wrong

Behaviour:
- Reset: all outputs 0, FSM=WAIT_INIT, skip counter 0, byte toggle 0, line/pixel counters 0, sync flops 0.
- Input stage: vsync, href and data are registered once (vs_r1, hs_r1, d_r1). vs_r2 holds the previous vs_r1. Frame start is fs = vs_r1 & ~vs_r2.
- FSM:
  - WAIT_INIT: when synchronised init_done=1, go to SKIP and clear the skip counter.
  - SKIP: on each fs, increment the counter. On the fs where the count equals FRAME_SKIP, go to CAPTURE. That fs begins the first captured frame. With FRAME_SKIP=0, the first fs after WAIT_INIT enters CAPTURE.
  - CAPTURE: stays here until reset or synchronised init_done=0. On init_done=0, go to WAIT_INIT immediately, abort the pending pixel, and emit no done/err pulse.
- Packing:
  - Active only in CAPTURE with hs_r1=1 and vs_r1=0.
  - The toggle flips each active cycle.
  - Toggle 0: latch d_r1 as the first byte.
  - Toggle 1: register the pixel {first,d_r1} (MSB_FIRST=1) or {d_r1,first}, and assert cmos_frame_we next cycle.
  - The toggle clears whenever hs_r1=0. An odd trailing byte is dropped and counted as a geometry error.
- Latency: the second byte present at pin edge N produces cmos_frame_we=1 and its data in the cycle after edge N+2 (2-cycle pipeline). Outputs are registered.
- Counters (CAPTURE only):
  - pix_cnt (11 bits, saturating) counts emitted pixels in the current line.
  - At the href falling edge (hs_r2 & ~hs_r1): if pix_cnt != H_PIXELS or an odd byte was seen, set a sticky err flag. Then increment line_cnt (10 bits, saturating) and clear pix_cnt.
- Frame end: on fs in CAPTURE, excluding the fs that entered CAPTURE:
  - pulse cmos_frame_done;
  - pulse cmos_frame_err if the sticky flag is set or line_cnt != V_LINES;
  - clear line_cnt, pix_cnt and the sticky flag.
- HREF while vs_r1=1 is ignored. cmos_frame_we is never asserted outside CAPTURE.
- Asynchronous rst at any point: return to the reset state in the same instant. A partial pixel is discarded.

Decomposition:
- Package cmos_capture_pkg holds:
  - state enum {WAIT_INIT, SKIP, CAPTURE} (2-bit);
  - default geometry constants (640, 480);
  - counter widths (skip 8, pix 11, line 10).
- One sub-module, cmos_byte_packer, contains the toggle, first-byte latch and output register, with inputs en/href/data and outputs we/data.
- The FSM, edge detection and counters stay in the top.

Test Plan:
- Init gating: init_done held 0 while 3 frames are driven -> cmos_frame_valid=0 and cmos_frame_we never 1. Raise init_done with FRAME_SKIP=2 -> valid rises on the 3rd fs after sync and stays 1.
- Packing: in CAPTURE, one line of bytes 0xAB,0xCD,0x12,0x34 -> two we pulses, data 0xABCD then 0x1234, each 2 cycles after the second byte. With MSB_FIRST=0 -> 0xCDAB, 0x3412.
- Good frame: H_PIXELS=4, V_LINES=2, drive 2 lines x 8 bytes then fs -> exactly 8 we pulses, frame_done=1 for 1 cycle, frame_err=0.
- Bad geometry: same setup, second line has 7 bytes -> 7 we pulses total (odd byte dropped), frame_done=1 and frame_err=1 on the same cycle. The next correct frame gives err=0.
- Init drop: deassert init_done mid-line in CAPTURE -> within 3 cycles valid=0, no further we, no done pulse. Re-asserting it -> SKIP repeats FRAME_SKIP frames.
- Async reset mid-line: rst pulse between the two bytes of a pair -> all outputs 0 immediately, no we for the partial pixel, FSM=WAIT_INIT.
